// File: rtl/param_packer_if.sv
// Stream bundle around param_packer.
// Input side : data_i (signed element), valid_i, last_i  -> ready_o
// Output side: data_o (packed packet), valid_o, last_o, short_o <- ready_i
// master: producer/consumer environment driving the packer.
// slave : the packer itself.
interface param_packer_if #(
  parameter int unsigned I_BW   = 8,
  parameter int unsigned N_ELEM = 13
) ();
  logic signed [I_BW-1:0]        data_i;
  logic                          valid_i;
  logic                          last_i;
  logic                          ready_o;
  logic [I_BW*N_ELEM-1:0]        data_o;
  logic                          valid_o;
  logic                          last_o;
  logic                          short_o;
  logic                          ready_i;

  modport master (
    output data_i, valid_i, last_i, ready_i,
    input  ready_o, data_o, valid_o, last_o, short_o
  );

  modport slave (
    input  data_i, valid_i, last_i, ready_i,
    output ready_o, data_o, valid_o, last_o, short_o
  );
endinterface

// File: rtl/param_packer.sv
// param_packer: collects N_ELEM elements of I_BW bits into one packed word.
// A frame may close a packet early via last_i; remaining slots are zero and
// short_o flags the packet. Two-stage buffering: a fill buffer plus an output
// register, so one complete packet can wait while the output is stalled.
// Ports:
//   clk_i   - clock, rising edge
//   rst_n_i - asynchronous active-low reset
//   en_i    - enable; low synchronously clears all state
//   bus     - stream bundle (slave side), see param_packer_if
module param_packer #(
  parameter int unsigned I_BW      = 8,
  parameter int unsigned N_ELEM    = 13,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           en_i,
  param_packer_if.slave  bus
);

  localparam int unsigned   CW       = $clog2(N_ELEM);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_ELEM - 1);

  typedef enum logic {FILLING, FULL_WAIT} state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q;
  logic [N_ELEM-1:0][I_BW-1:0]  fill_q, fill_d;
  logic                         fill_last_q, fill_short_q;
  logic [I_BW*N_ELEM-1:0]       data_q, pack_d;
  logic                         valid_q, last_q, short_q;

  logic ready, accept, is_final, close, out_free, consume, load_out;
  logic pkt_last, pkt_short;

  assign accept   = bus.valid_i & ready;
  assign is_final = (cnt_q == LAST_IDX);
  assign close    = accept & (bus.last_i | is_final);
  assign consume  = valid_q & bus.ready_i;
  assign out_free = ~valid_q | bus.ready_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= FILLING;
    end else if (!en_i) begin
      state_q <= FILLING;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILLING:   if (close && !out_free) state_d = FULL_WAIT;
      FULL_WAIT: if (consume)            state_d = FILLING;
      default:   state_d = FILLING;
    endcase
  end

  // FSM outputs: input acceptance and output-register load
  always_comb begin
    ready    = en_i & (state_q == FILLING);
    load_out = 1'b0;
    case (state_q)
      FILLING:   load_out = close & out_free;
      FULL_WAIT: load_out = consume;
      default:   load_out = 1'b0;
    endcase
  end

  // Fill buffer including the element accepted this cycle, so a closing
  // element can go straight to the output register without a bubble.
  always_comb begin
    fill_d = fill_q;
    if (accept) fill_d[cnt_q] = bus.data_i;
  end

  always_comb begin
    pack_d = '0;
    for (int unsigned k = 0; k < N_ELEM; k++) begin
      if (MSB_FIRST) pack_d[(N_ELEM-k)*I_BW-1 -: I_BW] = fill_d[k];
      else           pack_d[(k+1)*I_BW-1 -: I_BW]      = fill_d[k];
    end
  end

  // A waiting packet carries its flags in the fill-side registers.
  always_comb begin
    if (state_q == FULL_WAIT) begin
      pkt_last  = fill_last_q;
      pkt_short = fill_short_q;
    end else begin
      pkt_last  = bus.last_i;
      pkt_short = bus.last_i & ~is_final;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q        <= '0;
      fill_q       <= '0;
      fill_last_q  <= 1'b0;
      fill_short_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      short_q      <= 1'b0;
    end else if (!en_i) begin
      cnt_q        <= '0;
      fill_q       <= '0;
      fill_last_q  <= 1'b0;
      fill_short_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      if (accept) cnt_q <= close ? '0 : cnt_q + 1'b1;

      if (load_out) begin
        data_q       <= pack_d;
        valid_q      <= 1'b1;
        last_q       <= pkt_last;
        short_q      <= pkt_short;
        fill_q       <= '0;
        fill_last_q  <= 1'b0;
        fill_short_q <= 1'b0;
      end else begin
        if (consume) valid_q <= 1'b0;
        fill_q <= fill_d;
        if (close) begin
          fill_last_q  <= bus.last_i;
          fill_short_q <= bus.last_i & ~is_final;
        end
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.last_o  = last_q;
  assign bus.short_o = short_q;

endmodule

// File: tb/tb_param_packer.sv
// Bench for param_packer: two instances (MSB_FIRST=1 and 0) share stimulus;
// each has its own expected-packet queue checked by a monitor on handshake.
module tb_param_packer;

  typedef struct packed {
    logic [103:0] d;
    logic         l;
    logic         s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, en, vin, lin, rdy;
  logic [7:0] din;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  param_packer_if #(.I_BW(8), .N_ELEM(13)) if_a ();
  param_packer_if #(.I_BW(8), .N_ELEM(13)) if_b ();

  assign if_a.data_i  = din;
  assign if_a.valid_i = vin;
  assign if_a.last_i  = lin;
  assign if_a.ready_i = rdy;
  assign if_b.data_i  = din;
  assign if_b.valid_i = vin;
  assign if_b.last_i  = lin;
  assign if_b.ready_i = rdy;

  param_packer #(.I_BW(8), .N_ELEM(13), .MSB_FIRST(1'b1)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .bus(if_a)
  );
  param_packer #(.I_BW(8), .N_ELEM(13), .MSB_FIRST(1'b0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .bus(if_b)
  );

  // Scoreboard monitor: one comparison per completed output handshake.
  always @(negedge clk) begin
    if (if_a.valid_o && if_a.ready_i) begin
      vectors++;
      if (qa.size() == 0) begin
        miscompares++;
        $display("FAIL sb_a: unexpected packet data=%h, want none", if_a.data_o);
      end else begin
        ea = qa.pop_front();
        if ({if_a.data_o, if_a.last_o, if_a.short_o} !== ea) begin
          miscompares++;
          $display("FAIL sb_a: got data=%h last=%b short=%b, want data=%h last=%b short=%b",
                   if_a.data_o, if_a.last_o, if_a.short_o, ea.d, ea.l, ea.s);
        end
      end
    end
    if (if_b.valid_o && if_b.ready_i) begin
      vectors++;
      if (qb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_b: unexpected packet data=%h, want none", if_b.data_o);
      end else begin
        eb = qb.pop_front();
        if ({if_b.data_o, if_b.last_o, if_b.short_o} !== eb) begin
          miscompares++;
          $display("FAIL sb_b: got data=%h last=%b short=%b, want data=%h last=%b short=%b",
                   if_b.data_o, if_b.last_o, if_b.short_o, eb.d, eb.l, eb.s);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [103:0] got, input logic [103:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  // Present one element; returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l, input int gap);
    int unsigned n;
    n   = 0;
    din = d;
    lin = l;
    vin = 1'b1;
    @(negedge clk);
    while (!if_a.ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: ready_o stuck at 0, want 1");
    end
    @(posedge clk);
    #1;
    vin = 1'b0;
    lin = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [103:0] da, input logic [103:0] db,
                      input logic l, input logic s);
    qa.push_back('{d: da, l: l, s: s});
    qb.push_back('{d: db, l: l, s: s});
  endtask

  initial begin
    int unsigned waitc;
    rst_n = 1'b0; en = 1'b0; vin = 1'b0; lin = 1'b0; rdy = 1'b1; din = '0;
    #12;
    chk("rst_valid_o", {103'd0, if_a.valid_o}, 104'd0);
    chk("rst_data_o", if_a.data_o, 104'd0);
    chk("rst_short_o", {103'd0, if_b.short_o}, 104'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    #1;
    chk("ready_after_rst", {103'd0, if_a.ready_o}, 104'd1);
    idle(1);

    // Full packet, contiguous, last_i on 13th element
    push(104'h0102030405060708090A0B0C0D, 104'h0D0C0B0A090807060504030201, 1'b1, 1'b0);
    for (int i = 1; i <= 13; i++) send(8'(i), i == 13, 0);
    chk("latency_valid_o", {103'd0, if_a.valid_o}, 104'd1);
    chk("full_data_now", if_a.data_o, 104'h0102030405060708090A0B0C0D);
    idle(2);

    // Early close on the 5th element
    push(104'h11121314150000000000000000, 104'h00000000000000001514131211, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), i == 4, 0);
    idle(2);

    // Early close on the very first element
    push(104'h77000000000000000000000000, 104'h00000000000000000000000077, 1'b1, 1'b1);
    send(8'h77, 1'b1, 0);
    idle(2);

    // Output stalled: second packet waits in the fill buffer
    rdy = 1'b0;
    push(104'h2122232425262728292A2B2C2D, 104'h2D2C2B2A292827262524232221, 1'b0, 1'b0);
    push(104'h3132333435363738393A3B3C3D, 104'h3D3C3B3A393837363534333231, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) send(8'h21 + 8'(i), 1'b0, 0);
    for (int i = 0; i < 13; i++) send(8'h31 + 8'(i), 1'b0, 0);
    chk("stall_ready_o", {103'd0, if_a.ready_o}, 104'd0);
    chk("stall_valid_o", {103'd0, if_a.valid_o}, 104'd1);
    chk("stall_hold_data", if_a.data_o, 104'h2122232425262728292A2B2C2D);
    idle(2);
    chk("stall_hold_data2", if_a.data_o, 104'h2122232425262728292A2B2C2D);
    rdy = 1'b1;
    idle(1);
    rdy = 1'b0;
    chk("second_valid_o", {103'd0, if_a.valid_o}, 104'd1);
    chk("second_data_o", if_a.data_o, 104'h3132333435363738393A3B3C3D);
    chk("second_ready_o", {103'd0, if_a.ready_o}, 104'd1);
    rdy = 1'b1;
    idle(2);

    // 3-cycle gaps between elements
    push(104'h0102030405060708090A0B0C0D, 104'h0D0C0B0A090807060504030201, 1'b1, 1'b0);
    for (int i = 1; i <= 13; i++) send(8'(i), i == 13, 3);
    idle(2);

    // Enable drop mid-frame discards the partial packet
    for (int i = 0; i < 6; i++) send(8'h41 + 8'(i), 1'b0, 0);
    en = 1'b0;
    #1;
    chk("en_low_ready_o", {103'd0, if_a.ready_o}, 104'd0);
    idle(1);
    en = 1'b1;
    push(104'h5152535455565758595A5B5C5D, 104'h5D5C5B5A595857565554535251, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) send(8'h51 + 8'(i), i == 12, 0);
    idle(2);

    waitc = 0;
    while ((qa.size() != 0 || qb.size() != 0) && waitc < 50) begin
      idle(1);
      waitc++;
    end
    chk("queues_drained", 104'(qa.size() + qb.size()), 104'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
